// File: rtl/bit_stream_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_stream_serializer_pkg
//   Shared types and constants for the parallel-to-serial feeder that drives
//   the serial sequence detector.
//
//   Contents:
//     state_t        - serializer FSM state encoding {IDLE, SHIFT}
//     DEFAULT_WIDTH  - default parallel word width
//     cnt_width()    - bit-counter width derived from $clog2(WIDTH)
// -----------------------------------------------------------------------------
package bit_stream_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width of a counter that indexes bits 0..width-1. Never less than one bit
  // so that a degenerate width still yields a legal vector declaration.
  function automatic int cnt_width(input int width);
    if (width < 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage : bit_stream_serializer_pkg

// File: rtl/bit_stream_serializer_word_hold_reg.sv
// -----------------------------------------------------------------------------
// word_hold_reg
//   One-deep pending word register with a full flag. Holds the next word while
//   the current one is being shifted out.
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   synchronous active-high reset; empties the register
//     wr       in   write wr_data into the register this edge
//     wr_data  in   word to store
//     pop      in   release the stored word this edge
//     rd_data  out  stored word (meaningful only while full)
//     full     out  register holds a word
//
//   Pop and write on the same edge: the old word leaves, the new word is
//   stored and the register stays full.
// -----------------------------------------------------------------------------
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      full    <= 1'b0;
    end else begin
      if (wr) begin
        // A write wins over a pop: the freed slot is immediately refilled.
        rd_data <= wr_data;
        full    <= 1'b1;
      end else if (pop) begin
        full    <= 1'b0;
      end
    end
  end

endmodule : word_hold_reg

// File: rtl/bit_stream_serializer.sv
// -----------------------------------------------------------------------------
// bit_stream_serializer
//   Accepts parallel words over a valid/ready handshake and shifts them out
//   one bit per clock on a single-bit stream feeding the sequence detector.
//   One word lives in the shift register and one more may wait in a pending
//   register, so back-to-back words stream with no idle gap.
//
//   Parameters:
//     WIDTH       bits per word (>= 2)
//     LSB_FIRST   0: data_in[WIDTH-1] goes out first, 1: data_in[0] first
//     IDLE_LEVEL  level driven on out while nothing is shifting
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   synchronous active-high reset
//     data_in     in   parallel word to serialize
//     data_valid  in   data_in holds a word
//     data_ready  out  a word can be accepted this cycle
//     out         out  serial bit (registered)
//     out_valid   out  out carries a data bit rather than idle fill
//     word_done   out  one-cycle pulse alongside the last bit of each word
//     busy        out  shift register or pending register occupied
//
//   Handshake: a word transfers on a rising edge where data_valid and
//   data_ready are both high. data_ready is !pending_full, a pure register
//   function with no path from data_valid. data_in is ignored unless a
//   transfer happens. Once offered, a word is expected to stay on data_in
//   until it is accepted.
//
//   Timing: the first bit of a word is on out in the cycle after the accepting
//   edge; each word occupies exactly WIDTH consecutive cycles. The counter
//   holds the index of the bit currently on out.
// -----------------------------------------------------------------------------
module bit_stream_serializer
  import bit_stream_serializer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;   // bits not yet presented on out

  logic             pend_full;
  logic [WIDTH-1:0] pend_data;

  // ---------------------------------------------------------------------------
  // Bit-order helpers
  // ---------------------------------------------------------------------------
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and load decisions
  // ---------------------------------------------------------------------------
  logic xfer;
  logic last_bit;
  logic load_pend;
  logic load_direct;
  logic pend_wr;

  assign data_ready = !pend_full;
  assign busy       = (state == SHIFT) || pend_full;
  assign xfer       = data_valid && data_ready;
  assign last_bit   = (state == SHIFT) && (cnt == LAST);

  // The shift register is refilled from pending when the last bit is on out.
  assign load_pend   = last_bit && pend_full;

  // A word arriving while the shift register is free (IDLE), or exactly on
  // the last bit with nothing pending, goes straight into the shift register.
  // Parking it in pending instead would strand it when the FSM drops to IDLE.
  assign load_direct = xfer && ((state == IDLE) || (last_bit && !pend_full));

  assign pend_wr     = xfer && !load_direct;

  word_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr      (pend_wr),
    .wr_data (data_in),
    .pop     (load_pend),
    .rd_data (pend_data),
    .full    (pend_full)
  );

  // ---------------------------------------------------------------------------
  // Serializer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      out       <= IDLE_LEVEL;
      out_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_direct) begin
            out       <= head_bit(data_in);
            shreg     <= advance(data_in);
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (last_bit) begin
            if (load_pend) begin
              out       <= head_bit(pend_data);
              shreg     <= advance(pend_data);
              out_valid <= 1'b1;
              cnt       <= '0;
            end else if (load_direct) begin
              out       <= head_bit(data_in);
              shreg     <= advance(data_in);
              out_valid <= 1'b1;
              cnt       <= '0;
            end else begin
              out       <= IDLE_LEVEL;
              out_valid <= 1'b0;
              cnt       <= '0;
              state     <= IDLE;
            end
          end else begin
            out       <= head_bit(shreg);
            shreg     <= advance(shreg);
            cnt       <= cnt + 1'b1;
            // Raise the pulse on the edge that puts the last bit on out.
            word_done <= (cnt == PENULT);
          end
        end

        default: begin
          state     <= IDLE;
          out       <= IDLE_LEVEL;
          out_valid <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule : bit_stream_serializer

// File: tb/tb_bit_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_stream_serializer
//   Directed bench for bit_stream_serializer (WIDTH = 8, IDLE_LEVEL = 0).
//   Two instances share the stimulus: dut (MSB first) and dut_lsb (LSB first).
//   Expected bit streams are hand-written patterns pushed into exp_q.
// -----------------------------------------------------------------------------
module tb_bit_stream_serializer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;

  logic data_ready, out, out_valid, word_done, busy;
  logic data_ready_l, out_l, out_valid_l, word_done_l, busy_l;

  bit_stream_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out        (out),
    .out_valid  (out_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  bit_stream_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready_l),
    .out        (out_l),
    .out_valid  (out_valid_l),
    .word_done  (word_done_l),
    .busy       (busy_l)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int   checks   = 0;
  int   failures = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push the n low bits of pat, most significant first (first out first).
  task automatic push_bits(input logic [15:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(pat[i]);
  endtask

  task automatic check_bit(input string tag, input logic got);
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {31'd0, got}, {31'd0, e});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"},   {31'd0, out},        32'd0);
    check({tag, "_oval"},  {31'd0, out_valid},  32'd0);
    check({tag, "_done"},  {31'd0, word_done},  32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hB6;

    // ---- Reset with valid asserted: nothing accepted ----
    step();
    step();
    check_idle("rst");
    rst        = 1'b0;
    data_valid = 1'b0;
    step();
    check_idle("post_rst");

    // ---- Single word 0xB6, MSB first ----
    data_valid = 1'b1;
    data_in    = 8'hB6;
    step();
    data_valid = 1'b0;
    push_bits(16'b10110110, 8);
    for (int k = 0; k < 8; k++) begin
      check_bit($sformatf("single_bit%0d", k), out);
      check($sformatf("single_oval%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("single_done%0d", k), {31'd0, word_done}, (k == 7) ? 32'd1 : 32'd0);
      step();
    end
    check_idle("single_end");

    // ---- Back-to-back 0xB6, 0x5A ----
    data_valid = 1'b1;
    data_in    = 8'hB6;
    step();
    push_bits(16'b1011011001011010, 16);
    for (int k = 0; k < 16; k++) begin
      check_bit($sformatf("b2b_bit%0d", k), out);
      check($sformatf("b2b_oval%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("b2b_done%0d", k), {31'd0, word_done},
            (k == 7 || k == 15) ? 32'd1 : 32'd0);
      check($sformatf("b2b_ready%0d", k), {31'd0, data_ready},
            (k == 0 || k >= 8) ? 32'd1 : 32'd0);
      check($sformatf("b2b_busy%0d", k), {31'd0, busy}, 32'd1);
      if (k == 0) data_in = 8'h5A;
      if (k == 1) data_valid = 1'b0;
      step();
    end
    check_idle("b2b_end");

    // ---- LSB first, 0x0D ----
    data_valid = 1'b1;
    data_in    = 8'h0D;
    step();
    data_valid = 1'b0;
    push_bits(16'b10110000, 8);
    for (int k = 0; k < 8; k++) begin
      check_bit($sformatf("lsb_bit%0d", k), out_l);
      check($sformatf("lsb_oval%0d", k), {31'd0, out_valid_l}, 32'd1);
      check($sformatf("lsb_done%0d", k), {31'd0, word_done_l}, (k == 7) ? 32'd1 : 32'd0);
      step();
    end
    check("lsb_end_oval", {31'd0, out_valid_l}, 32'd0);
    check("lsb_end_out",  {31'd0, out_l},       32'd0);

    // ---- Reset mid-word with a pending word ----
    data_valid = 1'b1;
    data_in    = 8'hB6;
    step();                       // bit 0 on out
    data_in    = 8'h5A;
    step();                       // bit 1, 0x5A pending
    check("mid_ready_low", {31'd0, data_ready}, 32'd0);
    data_valid = 1'b0;
    step();                       // bit 2
    check("mid_bit2", {31'd0, out}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid_rst");
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("mid_quiet_oval%0d", k), {31'd0, out_valid}, 32'd0);
      check($sformatf("mid_quiet_done%0d", k), {31'd0, word_done}, 32'd0);
    end

    // ---- Gap: 0xFF, three idle cycles, 0x00 ----
    data_valid = 1'b1;
    data_in    = 8'hFF;
    step();
    data_valid = 1'b0;
    push_bits(16'hFF, 8);
    for (int k = 0; k < 8; k++) begin
      check_bit($sformatf("gap_ff_bit%0d", k), out);
      check($sformatf("gap_ff_oval%0d", k), {31'd0, out_valid}, 32'd1);
      step();
    end
    for (int g = 0; g < 3; g++) begin
      check($sformatf("gap_idle_oval%0d", g), {31'd0, out_valid}, 32'd0);
      check($sformatf("gap_idle_out%0d", g),  {31'd0, out},       32'd0);
      if (g == 2) begin
        data_valid = 1'b1;
        data_in    = 8'h00;
      end
      step();
    end
    data_valid = 1'b0;
    push_bits(16'h00, 8);
    for (int k = 0; k < 8; k++) begin
      check_bit($sformatf("gap_00_bit%0d", k), out);
      check($sformatf("gap_00_oval%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("gap_00_done%0d", k), {31'd0, word_done}, (k == 7) ? 32'd1 : 32'd0);
      step();
    end
    check_idle("gap_end");
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bit_stream_serializer
